// File: rtl/flash_block_reader.sv
// Block reader: walks a range of flash word addresses through a handshaking flash driver
// and streams each captured word downstream with its source address.
module flash_block_reader #(
  parameter int unsigned ADDR_W    = 23,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned ADDR_STEP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_cnt,
  output logic [ADDR_W-1:0] drv_addr,
  output logic              drv_enable_read,
  input  logic              drv_busy,
  input  logic [15:0]       drv_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StOutput,
    StFinish
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q;
  logic [CNT_W-1:0]    remaining_q;
  logic [15:0]         out_data_q;
  logic [ADDR_W-1:0]   out_addr_q;
  logic                rd_en_q, out_valid_q, busy_q, done_q;
  // Start accepted while the driver is still finishing an aborted read.
  logic                pend_q;
  logic                xfer;

  assign xfer = (state_q == StOutput) && out_ready && !abort;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (word_cnt == '0)   state_d = StFinish;
          else if (!drv_busy)   state_d = StIssue;
        end else if (pend_q && !drv_busy) begin
          state_d = StIssue;
        end
      end
      StIssue:    state_d = StWaitBusy;
      StWaitBusy: if (drv_busy) state_d = StWaitDone;
      StWaitDone: if (!drv_busy) state_d = StOutput;
      StOutput: begin
        if (out_ready) state_d = (remaining_q == CNT_W'(1)) ? StFinish : StIssue;
      end
      StFinish:   state_d = StIdle;
      default:    state_d = StIdle;
    endcase
    if (abort && (state_q != StIdle)) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_en_q     <= (state_d == StIssue);
      out_valid_q <= (state_d == StOutput);
      busy_q      <= (state_d != StIdle);
      // done trails the FINISH state by one registered cycle
      done_q      <= (state_q == StFinish) && !abort;

      if ((state_q == StIdle) && start) begin
        cur_addr_q  <= base_addr;
        remaining_q <= word_cnt;
        pend_q      <= (word_cnt != '0) && drv_busy;
      end else if ((state_q == StIdle) && pend_q && !drv_busy) begin
        pend_q <= 1'b0;
      end

      if ((state_q == StWaitDone) && !drv_busy && !abort) begin
        out_data_q <= drv_data;
        out_addr_q <= cur_addr_q;
      end

      if (xfer) begin
        remaining_q <= remaining_q - CNT_W'(1);
        cur_addr_q  <= cur_addr_q + ADDR_W'(ADDR_STEP);
      end
    end
  end

  assign drv_addr        = cur_addr_q;
  assign drv_enable_read = rd_en_q;
  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign out_addr        = out_addr_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_flash_block_reader.sv
// Scoreboard bench for flash_block_reader: a driver model answers read requests and a
// negedge monitor pops expected {addr, data} pairs on every downstream transfer.
module tb_flash_block_reader;

  typedef struct {
    logic [22:0] addr;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, drv_busy, out_ready;
  logic [22:0] base_addr, drv_addr, out_addr;
  logic [15:0] word_cnt, drv_data, out_data;
  logic        drv_enable_read, out_valid, busy, done;

  int checks = 0, errors = 0;
  int issue_cnt = 0, done_cnt = 0, xfer_cnt = 0;
  int busy_cycles = 4;
  exp_t        exp_q[$];
  logic [22:0] issue_q[$];

  flash_block_reader dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .base_addr       (base_addr),
    .word_cnt        (word_cnt),
    .drv_addr        (drv_addr),
    .drv_enable_read (drv_enable_read),
    .drv_busy        (drv_busy),
    .drv_data        (drv_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_addr        (out_addr),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [22:0] a, input logic [15:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start(input logic [22:0] b, input logic [15:0] c);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; word_cnt = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int  d0;
    bit  got;
    d0  = done_cnt;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (done_cnt != d0) begin
        got = 1'b1;
        break;
      end
    end
    chk(name, 32'(got), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk(name, 32'(got), 32'd1);
  endtask

  // Flash driver model: busy one cycle after the request, data = addr[15:0] ^ 16'h5A00.
  initial begin
    logic [22:0] a;
    drv_busy = 1'b0;
    drv_data = 16'h0;
    forever begin
      @(negedge clk);
      if (drv_enable_read === 1'b1) begin
        a = drv_addr;
        @(negedge clk);
        drv_busy = 1'b1;
        repeat (busy_cycles) @(negedge clk);
        drv_busy = 1'b0;
        drv_data = a[15:0] ^ 16'h5A00;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (drv_enable_read === 1'b1) begin
        issue_cnt++;
        issue_q.push_back(drv_addr);
      end
      if (done === 1'b1) done_cnt++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_xfer", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_addr", 32'(out_addr), 32'(e.addr));
          chk("out_data", 32'(out_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    int ic0, d0, x0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    base_addr = '0; word_cnt = '0;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_rd_en", 32'(drv_enable_read), 32'd0);
    chk("rst_drv_addr", 32'(drv_addr), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Three-word block from 0x10
    issue_q.delete();
    push_exp(23'h10, 16'h5A10);
    push_exp(23'h11, 16'h5A11);
    push_exp(23'h12, 16'h5A12);
    d0 = done_cnt;
    pulse_start(23'h10, 16'd3);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done("t1_done_seen");
    repeat (3) @(posedge clk);
    chk("t1_issue_n", 32'(issue_q.size()), 32'd3);
    if (issue_q.size() == 3) begin
      chk("t1_issue0", 32'(issue_q[0]), 32'h10);
      chk("t1_issue1", 32'(issue_q[1]), 32'h11);
      chk("t1_issue2", 32'(issue_q[2]), 32'h12);
    end
    chk("t1_done_n", 32'(done_cnt - d0), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);

    // Downstream stall: first word held for 10 cycles, no second read meanwhile
    out_ready = 1'b0;
    x0 = xfer_cnt;
    ic0 = issue_cnt;
    push_exp(23'h40, 16'h5A40);
    push_exp(23'h41, 16'h5A41);
    pulse_start(23'h40, 16'd2);
    wait_valid("t2_valid_seen");
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold_valid", 32'(out_valid), 32'd1);
      chk("t2_hold_data", 32'(out_data), 32'h5A40);
      chk("t2_hold_addr", 32'(out_addr), 32'h40);
      chk("t2_no_issue", 32'(issue_cnt - ic0), 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t2_valid_drop", 32'(out_valid), 32'd0);
    wait_done("t2_done_seen");
    chk("t2_xfers", 32'(xfer_cnt - x0), 32'd2);
    chk("t2_issues", 32'(issue_cnt - ic0), 32'd2);

    // Address wrap at the top of the space
    issue_q.delete();
    push_exp(23'h7FFFFF, 16'hA5FF);
    push_exp(23'h000000, 16'h5A00);
    pulse_start(23'h7FFFFF, 16'd2);
    wait_done("t3_done_seen");
    chk("t3_issue_n", 32'(issue_q.size()), 32'd2);
    if (issue_q.size() == 2) begin
      chk("t3_issue0", 32'(issue_q[0]), 32'h7FFFFF);
      chk("t3_issue1", 32'(issue_q[1]), 32'h0);
    end

    // Zero-length block: done two cycles after start, no read
    repeat (2) @(posedge clk);
    ic0 = issue_cnt;
    pulse_start(23'h55, 16'd0);
    chk("t4_done_e0", 32'(done), 32'd0);
    chk("t4_busy_e0", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("t4_done_e1", 32'(done), 32'd1);
    @(posedge clk); #1;
    chk("t4_done_e2", 32'(done), 32'd0);
    chk("t4_no_read", 32'(issue_cnt - ic0), 32'd0);

    // Abort during WAIT_DONE of word 2; restart must wait for drv_busy to drop
    busy_cycles = 12;
    issue_q.delete();
    ic0 = issue_cnt;
    push_exp(23'h100, 16'h5B00);
    pulse_start(23'h100, 16'd5);
    for (int i = 0; i < 100 && issue_cnt - ic0 < 2; i++) begin
      @(posedge clk); #1;
    end
    chk("t5_second_issue", 32'(issue_cnt - ic0), 32'd2);
    for (int i = 0; i < 20 && drv_busy !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    d0 = done_cnt;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t5_abort_busy", 32'(busy), 32'd0);
    chk("t5_abort_valid", 32'(out_valid), 32'd0);
    chk("t5_abort_rd_en", 32'(drv_enable_read), 32'd0);
    ic0 = issue_cnt;
    push_exp(23'h200, 16'h5800);
    pulse_start(23'h200, 16'd1);
    for (int i = 0; i < 40 && drv_busy === 1'b1; i++) begin
      chk("t5_wait_rd_en", 32'(drv_enable_read), 32'd0);
      chk("t5_wait_issue", 32'(issue_cnt - ic0), 32'd0);
      @(posedge clk); #1;
    end
    wait_done("t5_done_seen");
    chk("t5_done_n", 32'(done_cnt - d0), 32'd1);
    chk("t5_last_issue", 32'(issue_q[issue_q.size()-1]), 32'h200);
    busy_cycles = 4;

    // Asynchronous reset while a word sits in OUTPUT
    out_ready = 1'b0;
    pulse_start(23'h300, 16'd2);
    wait_valid("t6_valid_seen");
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_data", 32'(out_data), 32'd0);
    chk("t6_rst_addr", 32'(out_addr), 32'd0);
    chk("t6_rst_drv_addr", 32'(drv_addr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    ic0 = issue_cnt;
    d0 = done_cnt;
    repeat (6) @(posedge clk);
    #1;
    chk("t6_idle_busy", 32'(busy), 32'd0);
    chk("t6_no_issue", 32'(issue_cnt - ic0), 32'd0);
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
    push_exp(23'h300, 16'h5900);
    pulse_start(23'h300, 16'd1);
    wait_done("t6_done_seen");

    repeat (3) @(posedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/flash_block_reader.md
FLASH_BLOCK_READER -- requirements
Module: flash_block_reader

Interface
REQ-001 Parameter ADDR_W, 23, width of the flash word address.
REQ-002 Parameter CNT_W, 16, width of the word-count field.
REQ-003 Parameter ADDR_STEP, 1, address increment applied per word read.
REQ-004 Reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock; all state changes on posedge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  one-cycle request to begin a block read; sampled only in IDLE.
REQ-008 abort  in  1  cancels the current block and returns to IDLE.
REQ-009 base_addr  in  ADDR_W  first flash address of the block, latched on accepted start.
REQ-010 word_cnt  in  CNT_W  number of words to read, latched on accepted start.
REQ-011 drv_addr  out  ADDR_W  address presented to the flash driver.
REQ-012 drv_enable_read  out  1  read request to the flash driver.
REQ-013 drv_busy  in  1  flash driver busy flag.
REQ-014 drv_data  in  16  flash driver read data.
REQ-015 out_valid  out  1  captured word available downstream.
REQ-016 out_ready  in  1  downstream accepts the word.
REQ-017 out_data  out  16  captured word.
REQ-018 out_addr  out  ADDR_W  flash address the word came from.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 done  out  1  one-cycle pulse when a block completes normally.

Function
REQ-021 States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, OUTPUT, FINISH.
REQ-022 IDLE: start=1 latches base_addr into cur_addr and word_cnt into remaining; next state ISSUE if word_cnt!=0, else FINISH.
REQ-023 ISSUE: drv_enable_read=1 for exactly this one cycle; drv_addr=cur_addr; next state WAIT_BUSY.
REQ-024 drv_addr holds cur_addr continuously from ISSUE until the block leaves OUTPUT for that word.
REQ-025 WAIT_BUSY: stay until drv_busy=1, then go to WAIT_DONE; no timeout.
REQ-026 WAIT_DONE: stay while drv_busy=1; on the first cycle drv_busy=0, capture drv_data into out_data and cur_addr into out_addr, then go to OUTPUT.
REQ-027 OUTPUT: out_valid=1, out_data and out_addr stable; transfer occurs on a cycle with out_valid=1 and out_ready=1.
REQ-028 On transfer: remaining decrements by 1; cur_addr advances by ADDR_STEP modulo 2^ADDR_W; next state ISSUE if new remaining!=0, else FINISH.
REQ-029 out_valid deasserts in the cycle after transfer; no combinational path from out_ready to out_valid.
REQ-030 FINISH: done=1 for one cycle; next state IDLE.
REQ-031 start is ignored while busy=1.
REQ-032 abort=1 in any non-IDLE state forces IDLE next cycle, with out_valid=0, drv_enable_read=0, and no done pulse; abort has priority over all other transitions.
REQ-033 abort during WAIT_BUSY or WAIT_DONE does not wait for drv_busy to fall; a subsequent start proceeds to ISSUE only after drv_busy=0 is observed in IDLE.
REQ-034 Address wrap: cur_addr = 2^ADDR_W-1 with ADDR_STEP=1 wraps to 0 silently.
REQ-035 Maximum block length is 2^CNT_W-1 words; word_cnt=0 yields done without any read.

Reset
REQ-036 While rst_n=0: state IDLE; busy=0, done=0, out_valid=0, drv_enable_read=0.
REQ-037 While rst_n=0: drv_addr=0, out_data=0, out_addr=0, cur_addr=0, remaining=0.
REQ-038 Reset asserted mid-block discards the block immediately; no done pulse and no further drv_enable_read is issued.

Verification
REQ-039 Scenario: base_addr=0x000010, word_cnt=3, driver model busy for 4 cycles, out_ready=1 -> three ISSUE pulses at 0x10, 0x11, 0x12; three transfers with matching out_addr and data; one done pulse.
REQ-040 Scenario: word_cnt=2, out_ready=0 for 10 cycles after first out_valid -> out_data/out_addr held stable, no second ISSUE until the transfer, total two transfers.
REQ-041 Scenario: base_addr=0x7FFFFF, word_cnt=2 -> reads at 0x7FFFFF then 0x000000.
REQ-042 Scenario: word_cnt=0 -> done pulse two cycles after start, drv_enable_read never asserted.
REQ-043 Scenario: abort during WAIT_DONE of word 2 of 5 -> IDLE next cycle, no done; new start waits for drv_busy=0 before ISSUE.
REQ-044 Scenario: rst_n pulsed low during OUTPUT -> all outputs 0 immediately (asynchronous); block resumes only on new start.
